// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared helpers and types for the registered priority encoder.
//   clog2_min1(n) : index width for n requests, never less than 1 bit.
//   N_DEFAULT / W_DEFAULT / idx_t : default request count and index type.
package prio_enc_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int N_DEFAULT = 8;
  localparam int W_DEFAULT = clog2_min1(N_DEFAULT);

  typedef logic [W_DEFAULT-1:0] idx_t;

endpackage

// File: rtl/prio_enc_reg_if.sv
// prio_enc_reg_if: request/result handshake bundle of the priority encoder.
//   en, in[N], in_valid      : request side, driven by the producer
//   in_ready                 : encoder can accept this cycle
//   out[W], out_zero         : registered result (index, all-zero flag)
//   out_valid / out_ready    : result handshake toward the consumer
// Modports: master = producer/consumer side, slave = encoder side.
interface prio_enc_reg_if
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = clog2_min1(N)
) ();

  logic         en;
  logic [N-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out;
  logic         out_zero;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output en, in, in_valid, out_ready,
    input  in_ready, out, out_zero, out_valid
  );

  modport slave (
    input  en, in, in_valid, out_ready,
    output in_ready, out, out_zero, out_valid
  );

endinterface

// File: rtl/prio_enc_core.sv
// prio_enc_core: combinational priority search.
//   vec[N]   : request vector
//   start[W] : highest-priority position; search runs start, start-1, ..., 0,
//              N-1, ..., start+1
//   idx[W]   : winning position (0 when vec is all zero)
//   zero     : 1 when vec has no bit set
// start must be below N.
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         zero
);

  int pos;

  // Walk from the farthest distance toward start so that the nearest set
  // bit in priority order is the last one written.
  always_comb begin
    idx = '0;
    pos = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(start) - k;
      if (pos < 0) begin
        pos = pos + N;
      end
      if (vec[pos]) begin
        idx = W'(pos);
      end
    end
  end

  assign zero = ~|vec;

endmodule

// File: rtl/prio_enc_reg.sv
// prio_enc_reg: registered N-to-log2(N) priority encoder with valid/ready on
// both sides and a one-entry output register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : prio_enc_reg_if.slave (en, in, in_valid, in_ready, out,
//           out_zero, out_valid, out_ready)
// Optional macro RR_PRIORITY_EN: when defined, priority rotates so the last
// winner becomes lowest priority; otherwise the highest set index wins.
module prio_enc_reg
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = clog2_min1(N)
) (
  input logic         clk,
  input logic         rst_n,
  prio_enc_reg_if.slave bus
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  logic [W-1:0] out_reg;
  logic         zero_reg;
  logic         valid_reg;
  logic [W-1:0] start;
  logic [W-1:0] core_idx;
  logic         core_zero;
  logic         accept;

  // A drain and a new accept may share an edge, giving one result per cycle.
  assign bus.in_ready = bus.en && (!valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  prio_enc_core #(.N(N)) u_core (
    .vec   (bus.in),
    .start (start),
    .idx   (core_idx),
    .zero  (core_zero)
  );

`ifdef RR_PRIORITY_EN
  logic [W-1:0] ptr_reg;

  // Pointer moves just below the last winner; zero vectors leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= LAST_IDX;
    end else if (accept && !core_zero) begin
      ptr_reg <= (core_idx == '0) ? LAST_IDX : core_idx - 1'b1;
    end
  end

  assign start = ptr_reg;
`else
  assign start = LAST_IDX;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg   <= '0;
      zero_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else if (accept) begin
      out_reg   <= core_idx;
      zero_reg  <= core_zero;
      valid_reg <= 1'b1;
    end else if (bus.out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_zero  = zero_reg;
  assign bus.out_valid = valid_reg;

endmodule

// File: tb/tb_prio_enc_reg.sv
// tb_prio_enc_reg: self-checking bench for prio_enc_reg (N=8 main instance,
// N=5 instance for the non-power-of-two index range). Works with or without
// RR_PRIORITY_EN defined.
module tb_prio_enc_reg;
  import prio_enc_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // reference model state for the N=8 instance
  logic m_valid;
  int   m_out;
  logic m_zero;
  int   m_ptr;

  prio_enc_reg_if #(.N(8)) bus8 ();
  prio_enc_reg_if #(.N(5)) bus5 ();

  prio_enc_reg #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  prio_enc_reg #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Winner by the priority order p, p-1, ..., 0, 7, ..., p+1.
  // Fixed mode keeps p at 7, i.e. highest index wins.
  function automatic int ref_winner(input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++) begin
      if (v[(p - k + 8) % 8]) return (p - k + 8) % 8;
    end
    return 0;
  endfunction

  function automatic int onehot_index(input logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_out   = 0;
    m_zero  = 1'b0;
    m_ptr   = 7;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic drive_cycle(input logic e, input logic [7:0] v, input logic iv, input logic ordy);
    logic exp_ready;
    logic acc;
    int   w;
    bus8.en        = e;
    bus8.in        = v;
    bus8.in_valid  = iv;
    bus8.out_ready = ordy;
    #1;
    exp_ready = e && (!m_valid || ordy);
    check_eq("in_ready", 32'(bus8.in_ready), 32'(exp_ready));
    acc = iv && exp_ready;
    @(posedge clk);
    if (acc) begin
      w       = ref_winner(v, m_ptr);
      m_zero  = (v == 8'h00);
      m_out   = m_zero ? 0 : w;
      m_valid = 1'b1;
`ifdef RR_PRIORITY_EN
      if (!m_zero) m_ptr = (w == 0) ? 7 : w - 1;
`endif
      $display("txn in=%h out=%0d zero=%0d", v, m_out, m_zero);
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_eq("out_valid", 32'(bus8.out_valid), 32'(m_valid));
    check_eq("out", 32'(bus8.out), 32'(m_out));
    check_eq("out_zero", 32'(bus8.out_zero), 32'(m_zero));
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    logic [4:0] v5;
    int         exp_idx;
    checks   = 0;
    failures = 0;
    model_reset();
    rst_n = 1'b0;
    bus8.en = 1'b1; bus8.in = '0; bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    bus5.en = 1'b1; bus5.in = '0; bus5.in_valid = 1'b0; bus5.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(bus8.out_valid), 0);
    check_eq("rst_out", 32'(bus8.out), 0);
    check_eq("rst_out_zero", 32'(bus8.out_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // one-hot walk, full throughput
    for (int i = 0; i < 8; i++) begin
      v = 8'(1 << i);
      drive_cycle(1'b1, v, 1'b1, 1'b1);
      check_eq("walk_idx", 32'(bus8.out), 32'(i));
    end

    // zero and multi-hot vectors
    drive_cycle(1'b1, 8'h00, 1'b1, 1'b1);
    check_eq("zero_flag", 32'(bus8.out_zero), 1);
    drive_cycle(1'b1, 8'hA5, 1'b1, 1'b1);

    // back-pressure: result 4 held while 8'h02 waits, then loaded on drain
    drive_cycle(1'b1, 8'h10, 1'b1, 1'b1);
    repeat (3) begin
      drive_cycle(1'b1, 8'h02, 1'b1, 1'b0);
      check_eq("bp_hold", 32'(bus8.out), 4);
    end
    drive_cycle(1'b1, 8'h02, 1'b1, 1'b1);
    check_eq("bp_load", 32'(bus8.out), 1);

    // enable low: nothing accepted, held result still drains
    drive_cycle(1'b0, 8'h80, 1'b1, 1'b0);
    drive_cycle(1'b0, 8'h80, 1'b1, 1'b0);
    drive_cycle(1'b0, 8'h80, 1'b1, 1'b1);

    // asynchronous reset while stalled
    drive_cycle(1'b1, 8'h40, 1'b1, 1'b1);
    bus8.in = 8'h08; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(bus8.out_valid), 0);
    check_eq("arst_out", 32'(bus8.out), 0);
    check_eq("arst_out_zero", 32'(bus8.out_zero), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // repeated all-ones: rotates in round-robin mode, always 7 in fixed mode
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b1, 8'hFF, 1'b1, 1'b1);
`ifdef RR_PRIORITY_EN
      exp_idx = (15 - i) % 8;
`else
      exp_idx = 7;
`endif
      check_eq("allones_seq", 32'(bus8.out), 32'(exp_idx));
      if (i == 3) drive_cycle(1'b1, 8'h00, 1'b1, 1'b1);
    end

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: v = 8'h00;
        1: v = 8'(1 << $urandom_range(0, 7));
        default: v = 8'($urandom);
      endcase
      drive_cycle($urandom_range(0, 7) != 0, v, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0);
    end

    // non-power-of-two instance: one-hot and zero vectors, index stays below 5
    for (int n = 0; n < 20; n++) begin
      if (n == 0) v5 = 5'b10000;
      else if ($urandom_range(0, 4) == 0) v5 = 5'b00000;
      else v5 = 5'(1 << $urandom_range(0, 4));
      bus5.en = 1'b1; bus5.in = v5; bus5.in_valid = 1'b1; bus5.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("n5_out", 32'(bus5.out), 32'(onehot_index(v5)));
      check_eq("n5_zero", 32'(bus5.out_zero), 32'(v5 == 5'b0));
      check_eq("n5_range", 32'(bus5.out < 3'd5), 1);
      $display("txn5 in=%b out=%0d", v5, onehot_index(v5));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prio_enc_reg.md
Name: prio_enc_reg

Overview:
- Parametrised, registered N-to-log2(N) priority encoder with an enable input and a valid/ready handshake on both sides.
- Generalises the fixed 8-to-3 combinational encoder.
  - Adds a one-entry output register with back-pressure.
  - Adds a "no request" flag.
  - Adds optional round-robin priority.
- Sits between request sources (interrupt lines, arbiter requests) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request inputs; legal range 2..64, non-power-of-two allowed.
- W, $clog2(N), width of encoded index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  encoder enable; 0 blocks acceptance (in_ready forced 0).
- in  input  N  request vector, bit i = request i.
- in_valid  input  1  in/en sampled this cycle.
- in_ready  output  1  block can accept this cycle.
- out  output  W  encoded index of the winning request.
- out_zero  output  1  1 = accepted vector was all zeros (out = 0).
- out_valid  output  1  out/out_zero hold a result.
- out_ready  input  1  consumer takes result this cycle.

Behaviour:
- Reset: out=0, out_zero=0, out_valid=0, round-robin pointer=N-1. All asynchronous on rst_n falling edge.
- in_ready = en && (!out_valid || out_ready). Purely combinational; no dependency on in_valid.
- Accept = in_valid && in_ready. On accept, the result is registered at the next rising edge and out_valid=1. Latency is 1 cycle.
- Without accept: if out_valid && out_ready, out_valid drops to 0. Otherwise out, out_zero and out_valid hold.
- Simultaneous drain and accept (out_valid && out_ready && in_valid && en): the new result replaces the old one in the same edge and out_valid stays 1. This gives full throughput of one result per cycle.
- Fixed priority: the highest set index wins. Examples: in=8'b0000_0001 -> out=0; in=8'b1000_0001 -> out=7.
- in==0 on accept: out=0, out_zero=1, out_valid=1. Zero vectors are reported, not dropped.
- en falling while out_valid=1: the held result is unaffected and still drains on out_ready.
- Index width: out is zero-extended into W bits. No value >= N is ever produced.
- Reset asserted mid-stall drops any held result.

Optional Feature:
- Macro RR_PRIORITY_EN.
- Defined:
  - Priority search starts at pointer p and proceeds downward with wrap (p, p-1, ..., 0, N-1, ..., p+1).
  - After an accepted non-zero vector with winner g, p <= (g==0) ? N-1 : g-1. The last winner therefore becomes lowest priority.
  - p is unchanged on zero vectors and when there is no accept.
  - Reset p=N-1, so the first grant matches fixed priority.
- Undefined: the pointer register is absent and priority is fixed highest-index.

Decomposition:
- Shared package prio_enc_pkg:
  - function clog2_min1(N), returning at least 1.
  - localparam/typedef for index width.
- One sub-module, prio_enc_core: purely combinational. Takes vector and start pointer; returns index and zero flag. The registered wrapper instantiates it with start pointer tied to N-1 when RR_PRIORITY_EN is undefined.

Test Plan:
- Walk one-hot: N=8, en=1, out_ready=1, in_valid=1, in=1<<i for i=0..7 on consecutive cycles -> out=i exactly one cycle later, out_zero=0, out_valid continuous.
- Zero and multi-hot: in=8'h00 -> out=0, out_zero=1; in=8'hA5 -> out=7 (fixed mode).
- Back-pressure: accept in=8'h10, hold out_ready=0 for 3 cycles while offering in=8'h02 -> in_ready=0, out stays 4. Raise out_ready -> same edge loads out=1.
- Enable and reset: en=0 with in_valid=1 -> in_ready=0, out_valid unchanged. Assert rst_n=0 asynchronously mid-stall -> out_valid=0 and out=0 immediately.
- Non-power-of-two: N=5, in=5'b10000 -> out=3'd4. Never exceeds 4.
- RR (RR_PRIORITY_EN defined): N=4, repeat in=4'b1111 four times -> out sequence 3,2,1,0, then 3. in=4'b0000 in between leaves the sequence unchanged.
